avalon_reg_responder: RTL and testbench

Avalon-MM slave (responder) register bank answering the single-cycle read/write pulses of the team's Avalon master bench. It accepts one command at a time, stretches it with waitrequest for a fixed number of cycles, then commits the write or returns read data on the falling edge of waitrequest. It holds six RW control registers, one read-only version register and a reserved address space.

---
 rtl/avalon_reg_responder.sv | 136 +++++++++++++
 tb/tb_avalon_reg_responder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_reg_responder.sv
`default_nettype none
// ============================================================================
// Module   : avalon_reg_responder
// Purpose  : Avalon-MM register responder with fixed waitrequest stretching.
// Revision : 1.0 - initial release
// ============================================================================
module avalon_reg_responder #(
    parameter int         WAIT_CYCLES = 3,
    parameter logic [7:0] VERSION     = 8'hA5,
    parameter logic [7:0] RST_VAL     = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] address,
    input  logic       Write,
    input  logic       read,
    input  logic [7:0] writedata,
    output logic       waitrequest,
    output logic [7:0] readdata
);

    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_BUSY  = 1'b1;
    localparam logic [3:0] c_CNT_INIT = 4'(WAIT_CYCLES - 1);

    logic [0:0] r_state;
    logic [0:0] w_next_state;
    logic [3:0] r_cnt;
    logic [7:0] r_addr;
    logic [7:0] r_wdata;
    logic       r_is_write;
    logic [7:0] r_regs [0:5];
    logic [7:0] r_readdata;

    logic       w_accept;
    logic       w_done;
    logic       w_busy;
    logic       w_hit;
    logic [2:0] w_idx;
    logic [7:0] w_rd_val;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: if (read || Write) w_next_state = c_ST_BUSY;
            c_ST_BUSY: if (r_cnt == 4'd0) w_next_state = c_ST_IDLE;
            default:   w_next_state = c_ST_IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        w_busy   = (r_state == c_ST_BUSY);
        w_accept = (r_state == c_ST_IDLE) && (read || Write);
        w_done   = w_busy && (r_cnt == 4'd0);
    end

    // Address 6 folds into slot 5 since address 5 is the version constant
    always_comb begin
        w_hit = 1'b0;
        w_idx = 3'd0;
        case (r_addr)
            8'd0, 8'd1, 8'd2, 8'd3, 8'd4: begin
                w_hit = 1'b1;
                w_idx = r_addr[2:0];
            end
            8'd6: begin
                w_hit = 1'b1;
                w_idx = 3'd5;
            end
            default: begin
                w_hit = 1'b0;
                w_idx = 3'd0;
            end
        endcase
    end

    always_comb begin
        w_rd_val = 8'h00;
        if (r_addr == 8'd5) begin
            w_rd_val = VERSION;
        end else if (w_hit) begin
            w_rd_val = r_regs[w_idx];
        end
    end

    // Command capture and wait counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt      <= 4'd0;
            r_addr     <= 8'h00;
            r_wdata    <= 8'h00;
            r_is_write <= 1'b0;
        end else if (w_accept) begin
            r_cnt      <= c_CNT_INIT;
            r_addr     <= address;
            r_wdata    <= writedata;
            r_is_write <= Write;
        end else if (w_busy && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Commit on the edge that ends the wait window
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 6; i++) begin
                r_regs[i] <= RST_VAL;
            end
            r_readdata <= 8'h00;
        end else if (w_done) begin
            if (r_is_write) begin
                if (w_hit) begin
                    r_regs[w_idx] <= r_wdata;
                end
            end else begin
                r_readdata <= w_rd_val;
            end
        end
    end

    assign waitrequest = w_busy;
    assign readdata    = r_readdata;

endmodule
`default_nettype wire

// File: tb/tb_avalon_reg_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_avalon_reg_responder
// Purpose  : Scoreboard bench for avalon_reg_responder (WAIT_CYCLES = 3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_avalon_reg_responder;

    localparam int c_WAIT = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] address = 8'h00;
    logic       Write = 1'b0;
    logic       read = 1'b0;
    logic [7:0] writedata = 8'h00;
    logic       waitrequest;
    logic [7:0] readdata;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] mdl [0:255];
    logic [7:0] last_rd;
    logic [7:0] exp_q [$];

    avalon_reg_responder #(
        .WAIT_CYCLES (c_WAIT),
        .VERSION     (8'hA5),
        .RST_VAL     (8'h00)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .address     (address),
        .Write       (Write),
        .read        (read),
        .writedata   (writedata),
        .waitrequest (waitrequest),
        .readdata    (readdata)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] exp_read(input logic [7:0] a);
        if (a == 8'd5) return 8'hA5;
        if (a <= 8'd4 || a == 8'd6) return mdl[a];
        return 8'h00;
    endfunction

    task automatic mdl_write(input logic [7:0] a, input logic [7:0] d);
        if (a <= 8'd4 || a == 8'd6) mdl[a] = d;
    endtask

    task automatic mdl_reset();
        for (int i = 0; i < 256; i++) mdl[i] = 8'h00;
        last_rd = 8'h00;
    endtask

    // Issue one pulse, then count waitrequest-high cycles until it falls
    task automatic run_cmd(input logic rd, input logic wr, input logic [7:0] a,
                           input logic [7:0] d, output int wcyc, output logic [7:0] rdv);
        @(negedge clk);
        read = rd; Write = wr; address = a; writedata = d;
        @(negedge clk);
        read = 1'b0; Write = 1'b0;
        wcyc = 0;
        while (waitrequest === 1'b1 && wcyc < 50) begin
            wcyc++;
            @(negedge clk);
        end
        rdv = readdata;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (waitrequest !== 1'b0) $display("FAIL reset_waitrequest: got %b want 0", waitrequest);
        else n_pass++;
        n_checks++;
        if (readdata !== 8'h00) $display("FAIL reset_readdata: got %h want 00", readdata);
        else n_pass++;
        reset = 1'b1;
        mdl_reset();
    endtask

    task automatic test_read_map();
        int wc; logic [7:0] rv, ex;
        for (int a = 0; a < 8; a++) begin
            exp_q.push_back(exp_read(8'(a)));
            run_cmd(1'b1, 1'b0, 8'(a), 8'h00, wc, rv);
            ex = exp_q.pop_front();
            n_checks++;
            if (rv !== ex) $display("FAIL map_read a=%0d: got %h want %h", a, rv, ex);
            else n_pass++;
            n_checks++;
            if (wc != c_WAIT) $display("FAIL map_wait a=%0d: got %0d want %0d", a, wc, c_WAIT);
            else n_pass++;
            last_rd = ex;
        end
    endtask

    task automatic test_rw_regs();
        logic [7:0] wa [4] = '{8'd0, 8'd3, 8'd4, 8'd6};
        logic [7:0] wd [4] = '{8'h03, 8'h48, 8'h17, 8'hFF};
        int wc; logic [7:0] rv, ex;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(last_rd);
            mdl_write(wa[i], wd[i]);
            run_cmd(1'b0, 1'b1, wa[i], wd[i], wc, rv);
            ex = exp_q.pop_front();
            n_checks++;
            if (rv !== ex) $display("FAIL write_keeps_rd a=%0d: got %h want %h", wa[i], rv, ex);
            else n_pass++;
            n_checks++;
            if (wc != c_WAIT) $display("FAIL write_wait a=%0d: got %0d want %0d", wa[i], wc, c_WAIT);
            else n_pass++;
        end
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(exp_read(wa[i]));
            run_cmd(1'b1, 1'b0, wa[i], 8'h00, wc, rv);
            ex = exp_q.pop_front();
            n_checks++;
            if (rv !== ex) $display("FAIL rw_read a=%0d: got %h want %h", wa[i], rv, ex);
            else n_pass++;
            last_rd = ex;
        end
    endtask

    task automatic test_protected();
        logic [7:0] wa [2] = '{8'd5, 8'd7};
        logic [7:0] wd [2] = '{8'hFF, 8'hC8};
        int wc; logic [7:0] rv, ex;
        for (int i = 0; i < 2; i++) begin
            mdl_write(wa[i], wd[i]);
            run_cmd(1'b0, 1'b1, wa[i], wd[i], wc, rv);
            exp_q.push_back(exp_read(wa[i]));
            run_cmd(1'b1, 1'b0, wa[i], 8'h00, wc, rv);
            ex = exp_q.pop_front();
            n_checks++;
            if (rv !== ex) $display("FAIL protected_read a=%0d: got %h want %h", wa[i], rv, ex);
            else n_pass++;
            last_rd = ex;
        end
    endtask

    task automatic test_busy_ignore();
        int wc, extra; logic [7:0] rv, ex;
        exp_q.push_back(exp_read(8'd1));
        @(negedge clk);
        read = 1'b1; address = 8'd1;
        @(negedge clk);
        read = 1'b0; Write = 1'b1; address = 8'd1; writedata = 8'h42;
        wc = (waitrequest === 1'b1) ? 1 : 0;
        @(negedge clk);
        Write = 1'b0;
        while (waitrequest === 1'b1 && wc < 50) begin
            wc++;
            @(negedge clk);
        end
        rv = readdata;
        ex = exp_q.pop_front();
        n_checks++;
        if (rv !== ex) $display("FAIL busy_read: got %h want %h", rv, ex);
        else n_pass++;
        n_checks++;
        if (wc != c_WAIT) $display("FAIL busy_wait: got %0d want %0d", wc, c_WAIT);
        else n_pass++;
        last_rd = ex;
        extra = 0;
        repeat (4) begin
            @(negedge clk);
            if (waitrequest !== 1'b0) extra++;
        end
        n_checks++;
        if (extra != 0) $display("FAIL busy_second_window: got %0d high cycles want 0", extra);
        else n_pass++;
        exp_q.push_back(exp_read(8'd1));
        run_cmd(1'b1, 1'b0, 8'd1, 8'h00, wc, rv);
        ex = exp_q.pop_front();
        n_checks++;
        if (rv !== ex) $display("FAIL busy_write_dropped: got %h want %h", rv, ex);
        else n_pass++;
        last_rd = ex;
    endtask

    task automatic test_both_pulses();
        int wc; logic [7:0] rv, ex;
        exp_q.push_back(last_rd);
        mdl_write(8'd2, 8'h99);
        run_cmd(1'b1, 1'b1, 8'd2, 8'h99, wc, rv);
        ex = exp_q.pop_front();
        n_checks++;
        if (rv !== ex) $display("FAIL both_keeps_rd: got %h want %h", rv, ex);
        else n_pass++;
        exp_q.push_back(exp_read(8'd2));
        run_cmd(1'b1, 1'b0, 8'd2, 8'h00, wc, rv);
        ex = exp_q.pop_front();
        n_checks++;
        if (rv !== ex) $display("FAIL both_write_won: got %h want %h", rv, ex);
        else n_pass++;
        last_rd = ex;
    endtask

    task automatic test_reset_mid();
        int wc; logic [7:0] rv, ex;
        @(negedge clk);
        Write = 1'b1; address = 8'd0; writedata = 8'h18;
        @(negedge clk);
        Write = 1'b0;
        reset = 1'b0;
        n_checks++;
        if (waitrequest !== 1'b1) $display("FAIL midrst_busy: got %b want 1", waitrequest);
        else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        mdl_reset();
        n_checks++;
        if (waitrequest !== 1'b0) $display("FAIL midrst_waitrequest: got %b want 0", waitrequest);
        else n_pass++;
        n_checks++;
        if (readdata !== last_rd) $display("FAIL midrst_readdata: got %h want %h", readdata, last_rd);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (waitrequest !== 1'b0) $display("FAIL midrst_stays_idle: got %b want 0", waitrequest);
        else n_pass++;
        exp_q.push_back(exp_read(8'd0));
        run_cmd(1'b1, 1'b0, 8'd0, 8'h00, wc, rv);
        ex = exp_q.pop_front();
        n_checks++;
        if (rv !== ex) $display("FAIL midrst_no_commit: got %h want %h", rv, ex);
        else n_pass++;
        last_rd = ex;
    endtask

    initial begin
        mdl_reset();
        test_reset();
        test_read_map();
        test_rw_regs();
        test_protected();
        test_busy_ignore();
        test_both_pulses();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
